// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the instruction/data memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_MEM_ADDR_W = 32;
    localparam int c_MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                        we;
        logic [c_MEM_DATA_W/8-1:0]   be;
        logic [c_MEM_ADDR_W-1:0]     addr;
        logic [c_MEM_DATA_W-1:0]     wdata;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_timer
// Description : Transaction watchdog; cleared on grant, counts busy cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);

    localparam int              c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_count;

    assign o_expire = (r_count == c_LAST);

    // Holds at the last value so a stalled exit cannot wrap the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_count && !o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between fetch and load/store, with
//               data priority, fetch anti-starvation, abort and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = c_MEM_ADDR_W,
    parameter int DATA_W     = c_MEM_DATA_W,
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_abort,
    output logic                i_done,
    output logic                i_err,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_done,
    output logic                d_err,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_done,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy
);

    localparam logic [1:0] c_ST_IDLE   = ARB_IDLE;
    localparam logic [1:0] c_ST_BUSY_I = ARB_BUSY_I;
    localparam logic [1:0] c_ST_BUSY_D = ARB_BUSY_D;
    localparam int         c_STREAK_W  = $clog2(STREAK_MAX + 1);

    logic [1:0]            r_state;
    logic [c_STREAK_W-1:0] r_streak;
    logic                  r_drop;
    mem_req_t              r_req;

    logic w_idle;
    logic w_i_live;
    logic w_d_live;
    logic w_streak_full;
    logic w_grant_d;
    logic w_grant_i;
    logic w_expire;
    logic w_finish;
    logic w_timeout;
    logic w_drop_now;

    assign m_we    = r_req.we;
    assign m_be    = r_req.be;
    assign m_addr  = r_req.addr;
    assign m_wdata = r_req.wdata;

    // A requester still holding req during its own done pulse is already served.
    assign w_idle        = (r_state == c_ST_IDLE);
    assign w_i_live      = i_req && !i_done;
    assign w_d_live      = d_req && !d_done;
    assign w_streak_full = (r_streak == c_STREAK_W'(STREAK_MAX));
    assign w_grant_d     = w_idle && w_d_live && !(w_i_live && w_streak_full);
    assign w_grant_i     = w_idle && !w_grant_d && w_i_live && !i_abort;
    assign w_finish      = !w_idle && (m_done || w_expire);
    assign w_timeout     = !m_done && w_expire;
    assign w_drop_now    = r_drop || i_abort;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_grant_d || w_grant_i),
        .i_count  (!w_idle),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_streak <= '0;
            r_drop   <= 1'b0;
            r_req    <= '0;
            m_req    <= 1'b0;
            busy     <= 1'b0;
            i_done   <= 1'b0;
            i_err    <= 1'b0;
            i_rdata  <= '0;
            d_done   <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            i_done <= 1'b0;
            i_err  <= 1'b0;
            d_done <= 1'b0;
            d_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_d) begin
                        r_state     <= c_ST_BUSY_D;
                        m_req       <= 1'b1;
                        busy        <= 1'b1;
                        r_streak    <= w_i_live ? r_streak + 1'b1 : '0;
                        r_req.we    <= d_we;
                        r_req.be    <= d_be;
                        r_req.addr  <= d_addr;
                        r_req.wdata <= d_wdata;
                    end else if (w_grant_i) begin
                        r_state     <= c_ST_BUSY_I;
                        m_req       <= 1'b1;
                        busy        <= 1'b1;
                        r_streak    <= '0;
                        r_req.we    <= 1'b0;
                        r_req.be    <= '1;
                        r_req.addr  <= i_addr;
                        r_req.wdata <= '0;
                    end
                end
                c_ST_BUSY_I: begin
                    if (w_finish) begin
                        r_state <= c_ST_IDLE;
                        m_req   <= 1'b0;
                        busy    <= 1'b0;
                        r_drop  <= 1'b0;
                        if (!w_drop_now) begin
                            i_done  <= 1'b1;
                            i_err   <= w_timeout;
                            i_rdata <= w_timeout ? '0 : m_rdata;
                        end
                    end else begin
                        r_drop <= w_drop_now;
                    end
                end
                c_ST_BUSY_D: begin
                    if (w_finish) begin
                        r_state <= c_ST_IDLE;
                        m_req   <= 1'b0;
                        busy    <= 1'b0;
                        d_done  <= 1'b1;
                        d_err   <= w_timeout;
                        d_rdata <= (w_timeout || r_req.we) ? '0 : m_rdata;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    m_req   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench: directed scenarios plus random traffic
//               compared each cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = DATA_W / 8;
    localparam int STREAK_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_req = 1'b0, i_abort = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_done, i_err;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req = 1'b0, d_we = 1'b0;
    logic [BE_W-1:0]   d_be = '0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_done, d_err;
    logic [DATA_W-1:0] d_rdata;
    logic              m_req, m_we;
    logic [BE_W-1:0]   m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_done = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STREAK_MAX (STREAK_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk     (clk),     .rst     (rst),
        .i_req   (i_req),   .i_addr  (i_addr),  .i_abort (i_abort),
        .i_done  (i_done),  .i_err   (i_err),   .i_rdata (i_rdata),
        .d_req   (d_req),   .d_we    (d_we),    .d_be    (d_be),
        .d_addr  (d_addr),  .d_wdata (d_wdata),
        .d_done  (d_done),  .d_err   (d_err),   .d_rdata (d_rdata),
        .m_req   (m_req),   .m_we    (m_we),    .m_be    (m_be),
        .m_addr  (m_addr),  .m_wdata (m_wdata),
        .m_done  (m_done),  .m_rdata (m_rdata), .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference: who owns the port, how long it has
    // waited, and what the requesters must see next cycle.
    // ------------------------------------------------------------------
    typedef struct {
        bit          i_done, i_err, d_done, d_err, m_req, m_we;
        logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
        logic [3:0]  m_be;
    } exp_t;

    initial begin : model
        exp_t e, nx;
        int   owner;     // 0 none, 1 fetch, 2 data
        int   streak;
        int   waited;
        bit   drop, i_live, d_live, expired;
        e = '{default: '0};
        owner = 0; streak = 0; waited = 0; drop = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                e = '{default: '0};
                owner = 0; streak = 0; waited = 0; drop = 0;
            end
            chk("m_req",  m_req,  e.m_req);
            chk("busy",   busy,   owner != 0);
            chk("i_done", i_done, e.i_done);
            chk("i_err",  i_err,  e.i_err);
            chk("d_done", d_done, e.d_done);
            chk("d_err",  d_err,  e.d_err);
            if (e.i_done) chk("i_rdata", i_rdata, e.i_rdata);
            if (e.d_done) chk("d_rdata", d_rdata, e.d_rdata);
            if (owner != 0) begin
                chk("m_addr", m_addr, e.m_addr);
                chk("m_we",   m_we,   e.m_we);
            end
            if (owner == 2) begin
                chk("m_be",    m_be,    e.m_be);
                chk("m_wdata", m_wdata, e.m_wdata);
            end
            if (!rst) begin
                nx = e;
                nx.i_done = 0; nx.i_err = 0; nx.d_done = 0; nx.d_err = 0;
                if (owner == 0) begin
                    i_live = i_req && !e.i_done;
                    d_live = d_req && !e.d_done;
                    waited = 0;
                    drop   = 0;
                    if (d_live && !(i_live && streak == STREAK_MAX)) begin
                        owner      = 2;
                        streak     = i_live ? ((streak + 1 > STREAK_MAX) ? STREAK_MAX : streak + 1) : 0;
                        nx.m_we    = d_we;
                        nx.m_be    = d_be;
                        nx.m_addr  = d_addr;
                        nx.m_wdata = d_wdata;
                    end else if (i_live && !i_abort) begin
                        owner     = 1;
                        streak    = 0;
                        nx.m_we   = 0;
                        nx.m_addr = i_addr;
                    end
                end else begin
                    expired = !m_done && (waited == TIMEOUT - 1);
                    if (owner == 1 && i_abort) drop = 1;
                    if (m_done || expired) begin
                        if (owner == 2) begin
                            nx.d_done  = 1;
                            nx.d_err   = expired;
                            nx.d_rdata = (expired || e.m_we) ? 32'h0 : m_rdata;
                        end else if (!drop) begin
                            nx.i_done  = 1;
                            nx.i_err   = expired;
                            nx.i_rdata = expired ? 32'h0 : m_rdata;
                        end
                        owner = 0;
                        drop  = 0;
                    end else begin
                        waited++;
                    end
                end
                nx.m_req = (owner != 0);
                e = nx;
            end
        end
    end

    task automatic drain();
        i_req = 0; d_req = 0; i_abort = 0;
        m_done = 1;
        repeat (3) tick();
        m_done = 0;
        tick();
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin : stim
        int seq[6];
        int exp_seq[6];
        int grants;
        bit prev;
        exp_seq = '{2, 2, 2, 2, 1, 2};

        // Reset state
        repeat (3) tick();
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dones", {i_done, i_err, d_done, d_err}, 4'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        rst = 0;
        tick();

        // Fetch only, m_done three cycles after m_req rises
        i_req = 1; i_addr = 32'h10;
        tick();
        chk("t1_m_req", m_req, 1'b1);
        chk("t1_m_addr", m_addr, 32'h10);
        tick(); tick(); tick();
        m_done = 1; m_rdata = 32'hDEADBEEF;
        tick();
        m_done = 0;
        chk("t1_i_done", i_done, 1'b1);
        chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
        tick();
        i_req = 0;
        chk("t1_no_regrant", m_req, 1'b0);
        chk("t1_done_pulse", i_done, 1'b0);
        tick();

        // Simultaneous fetch and store: data first
        i_req = 1; i_addr = 32'h40;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55; d_be = 4'hF;
        tick();
        chk("t2_m_we", m_we, 1'b1);
        chk("t2_m_addr", m_addr, 32'h20);
        chk("t2_m_wdata", m_wdata, 32'h55);
        chk("t2_m_be", m_be, 4'hF);
        m_done = 1; m_rdata = 32'h12345678;
        tick();
        chk("t2_d_done", d_done, 1'b1);
        chk("t2_d_rdata", d_rdata, 32'h0);
        m_done = 0; d_req = 0; d_we = 0;
        tick();
        chk("t2_i_grant", m_addr, 32'h40);
        chk("t2_i_we", m_we, 1'b0);
        m_done = 1; m_rdata = 32'hCAFE0001;
        tick();
        chk("t2_i_done", i_done, 1'b1);
        i_req = 0; m_done = 0;
        tick();

        // Streak: fetch is held off by an abort only in the data done cycles
        i_req = 1; i_addr = 32'h80;
        d_req = 1; d_we = 0; d_addr = 32'h90;
        grants = 0; prev = 0;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            tick();
            if (m_req && !prev) begin
                seq[grants] = (m_addr == 32'h90) ? 2 : 1;
                grants++;
            end
            prev    = m_req;
            m_done  = m_req;
            i_abort = d_done;
        end
        chk("t3_grant_count", grants, 6);
        for (int k = 0; k < 6; k++) chk("t3_grant_order", seq[k], exp_seq[k]);
        drain();

        // Abort while fetch in flight
        i_req = 1; i_addr = 32'h70;
        tick();
        i_abort = 1;
        tick();
        i_abort = 0; i_req = 0;
        tick(); tick();
        chk("t4_m_req_held", m_req, 1'b1);
        m_done = 1;
        tick();
        chk("t4_no_i_done", i_done, 1'b0);
        chk("t4_released", m_req, 1'b0);
        m_done = 0;
        i_req = 1; i_addr = 32'h30;
        tick();
        chk("t4_regrant", m_addr, 32'h30);
        m_done = 1; m_rdata = 32'h0BAD_F00D;
        tick();
        chk("t4_i_done", i_done, 1'b1);
        i_req = 0; m_done = 0;
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            i_req   = ($urandom % 10) < 7;
            i_addr  = $urandom;
            i_abort = ($urandom % 10) == 0;
            d_req   = ($urandom % 10) < 6;
            d_we    = $urandom % 2;
            d_be    = 4'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
            m_done  = ($urandom % 100) < (((c / 250) % 2 == 1) ? 4 : 35);
            m_rdata = $urandom;
        end
        drain();

        // Timeout on a hung load
        d_req = 1; d_we = 0; d_addr = 32'h44;
        tick();
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            tick();
            chk("t5_still_busy", m_req, 1'b1);
        end
        tick();
        chk("t5_d_done", d_done, 1'b1);
        chk("t5_d_err", d_err, 1'b1);
        chk("t5_d_rdata", d_rdata, 32'h0);
        chk("t5_busy", busy, 1'b0);
        d_req = 0;
        tick();
        m_done = 1; m_rdata = 32'h77;
        tick();
        m_done = 0;
        chk("t5_late_done", {busy, d_done, d_err, m_req}, 4'h0);
        tick();

        // Asynchronous reset in the middle of a load
        d_req = 1; d_we = 0; d_addr = 32'h50;
        tick();
        tick();
        chk("t6_pre_busy", busy, 1'b1);
        #2 rst = 1;
        #1;
        chk("t6_rst_m_req", m_req, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_d_done", d_done, 1'b0);
        @(posedge clk);
        #1 rst = 0;
        tick();
        chk("t6_regrant", m_addr, 32'h50);
        chk("t6_regrant_req", m_req, 1'b1);
        m_done = 1; m_rdata = 32'h1234;
        tick();
        chk("t6_d_done", d_done, 1'b1);
        chk("t6_d_rdata", d_rdata, 32'h1234);
        d_req = 0; m_done = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
